// File: rtl/hazard_stall_if.sv
// Hazard/stall control bundle between the pipeline and
// hazard_stall_unit: ID/EX hazard info in, stage controls out.
interface hazard_stall_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       idex_rd;
  logic             idex_mem_read;
  logic             idex_multicycle;
  logic             branch_taken;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             idex_hold;
  logic             exmem_bubble;
  logic             ifid_flush;
  logic             idex_flush;
  logic             mc_busy;
  logic             mc_done;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2,
    output id_uses_rs1, id_uses_rs2,
    output idex_rd, idex_mem_read,
    output idex_multicycle, branch_taken,
    input  pc_write, ifid_write,
    input  idex_bubble, idex_hold,
    input  exmem_bubble,
    input  ifid_flush, idex_flush,
    input  mc_busy, mc_done,
    input  stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2,
    input  id_uses_rs1, id_uses_rs2,
    input  idex_rd, idex_mem_read,
    input  idex_multicycle, branch_taken,
    output pc_write, ifid_write,
    output idex_bubble, idex_hold,
    output exmem_bubble,
    output ifid_flush, idex_flush,
    output mc_busy, mc_done,
    output stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use / multi-cycle stall and branch flush control for
// the 5-stage pipeline, with saturating stall/flush counters.
module hazard_stall_unit #(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input logic          clk,
  input logic          reset,
  hazard_stall_if.slave hz
);
  localparam int CW = $clog2(MC_LATENCY) + 1;
  localparam logic [CW-1:0] CNT_INIT =
    (MC_LATENCY > 1) ? CW'(MC_LATENCY - 2) : '0;

  typedef enum logic {RUN, MC_WAIT} state_t;

  state_t           state, nxt_state;
  logic [CW-1:0]    cnt, nxt_cnt;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic pc_write, ifid_write;
  logic idex_bubble, idex_hold;
  logic exmem_bubble, mc_done;
  logic ifid_flush, idex_flush;
  logic load_use, rs1_hit, rs2_hit;

  assign rs1_hit = hz.id_uses_rs1 &&
                   (hz.id_rs1 == hz.idex_rd);
  assign rs2_hit = hz.id_uses_rs2 &&
                   (hz.id_rs2 == hz.idex_rd);
  assign load_use = hz.idex_mem_read &&
                    (hz.idex_rd != 5'd0) &&
                    (rs1_hit || rs2_hit);

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_bubble  = 1'b0;
    idex_hold    = 1'b0;
    exmem_bubble = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    mc_done      = 1'b0;
    nxt_state    = state;
    nxt_cnt      = cnt;
    if (!reset) begin
      unique case (state)
        RUN: begin
          if (hz.branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (hz.idex_multicycle &&
                       (MC_LATENCY > 1)) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
            nxt_cnt      = CNT_INIT;
            nxt_state    = MC_WAIT;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        MC_WAIT: begin
          if (cnt != '0) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
            nxt_cnt      = cnt - CW'(1);
          end else begin
            mc_done   = 1'b1;
            nxt_state = RUN;
          end
        end
        default: nxt_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  // counters stick at all-ones rather than wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
      if (ifid_flush && (flush_q != '1))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.ifid_write   = ifid_write;
  assign hz.idex_bubble  = idex_bubble;
  assign hz.idex_hold    = idex_hold;
  assign hz.exmem_bubble = exmem_bubble;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_flush   = idex_flush;
  assign hz.mc_busy      = (state == MC_WAIT);
  assign hz.mc_done      = mc_done;
  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;
endmodule
